// File: rtl/bsg_abs_rr_sched.sv
// Round-robin front end sharing one absolute-value unit among els_p lanes,
// with a one-entry valid/yumi output register carrying tag and overflow flag.
module bsg_abs_rr_sched #(
  parameter int width_p = 16,
  parameter int els_p   = 4,
  localparam int tag_w_lp = (els_p == 1) ? 1 : $clog2(els_p)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [els_p-1:0]           v_i,
  input  logic [els_p*width_p-1:0]   data_i,
  output logic [els_p-1:0]           ready_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  output logic [tag_w_lp-1:0]        tag_o,
  output logic                       ovf_o,
  input  logic                       yumi_i
);

  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_e;

  localparam logic [width_p-1:0] min_neg_lp = {1'b1, {(width_p-1){1'b0}}};

  state_e                state_r, state_n_s;
  logic [tag_w_lp-1:0]   ptr_r;
  logic [width_p-1:0]    data_r;
  logic [tag_w_lp-1:0]   tag_r;
  logic                  ovf_r;
  logic                  open_s;
  logic                  grant_v_s;
  logic [tag_w_lp-1:0]   grant_idx_s;
  logic [width_p-1:0]    operand_s;
  logic                  yumi_s;

  function automatic logic [width_p-1:0] abs_f(input logic [width_p-1:0] x);
    logic [width_p-1:0] r;
    if (x[width_p-1]) begin
      r = (~x) + {{(width_p-1){1'b0}}, 1'b1};
    end else begin
      r = x;
    end
    return r;
  endfunction

  // A yumi while empty is a protocol error and must not disturb state.
  assign yumi_s = yumi_i & (state_r == FULL);
  assign open_s = (state_r == EMPTY) | yumi_s;

  // Round-robin search: scan offsets high to low so the lowest offset from ptr wins.
  always_comb begin
    logic [tag_w_lp-1:0] idx;
    grant_v_s   = 1'b0;
    grant_idx_s = '0;
    for (int k = els_p - 1; k >= 0; k--) begin
      idx = tag_w_lp'((int'(ptr_r) + k) % els_p);
      if (v_i[idx] && open_s && !reset_i) begin
        grant_v_s   = 1'b1;
        grant_idx_s = idx;
      end else begin
        grant_v_s   = grant_v_s;
      end
    end
  end

  // One-hot grant and the operand it selects.
  always_comb begin
    ready_o   = '0;
    operand_s = data_i[int'(grant_idx_s)*width_p +: width_p];
    if (grant_v_s) begin
      ready_o[grant_idx_s] = 1'b1;
    end else begin
      ready_o = '0;
    end
  end

  // Next-state logic for the output register occupancy.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      EMPTY: begin
        if (grant_v_s) state_n_s = FULL;
        else           state_n_s = EMPTY;
      end
      FULL: begin
        if (grant_v_s)   state_n_s = FULL;
        else if (yumi_s) state_n_s = EMPTY;
        else             state_n_s = FULL;
      end
      default: state_n_s = EMPTY;
    endcase
  end

  // Occupancy state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= EMPTY;
    else         state_r <= state_n_s;
  end

  // Result payload and round-robin pointer; payload holds unless a grant reloads it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_r <= '0;
      tag_r  <= '0;
      ovf_r  <= 1'b0;
      ptr_r  <= '0;
    end else if (grant_v_s) begin
      data_r <= abs_f(operand_s);
      tag_r  <= grant_idx_s;
      ovf_r  <= (operand_s == min_neg_lp);
      ptr_r  <= tag_w_lp'((int'(grant_idx_s) + 1) % els_p);
    end else begin
      data_r <= data_r;
      tag_r  <= tag_r;
      ovf_r  <= ovf_r;
      ptr_r  <= ptr_r;
    end
  end

  assign v_o    = (state_r == FULL);
  assign data_o = data_r;
  assign tag_o  = tag_r;
  assign ovf_o  = ovf_r;

  bsg_abs_rr_sched_chk u_chk (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_o     (v_o),
    .yumi_i  (yumi_i)
  );

endmodule

// Protocol checker: the consumer may only yumi a valid result.
module bsg_abs_rr_sched_chk (
  input logic clk_i,
  input logic reset_i,
  input logic v_o,
  input logic yumi_i
);
  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o))
    else $error("yumi_i asserted while v_o=0");
endmodule

// File: tb/tb_bsg_abs_rr_sched.sv
// Randomized bench for bsg_abs_rr_sched against a queue-free behavioural model
// of the round-robin grant and absolute-value result register.
module tb_bsg_abs_rr_sched;
  localparam int W = 16;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_i = 1'b1;
  logic [N-1:0]   v_i = '0;
  logic [N*W-1:0] data_i = '0;
  logic [N-1:0]   ready_o;
  logic           v_o;
  logic [W-1:0]   data_o;
  logic [1:0]     tag_o;
  logic           ovf_o;
  logic           yumi_i = 1'b0;

  bsg_abs_rr_sched #(.width_p(W), .els_p(N)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .v_o(v_o), .data_o(data_o), .tag_o(tag_o), .ovf_o(ovf_o), .yumi_i(yumi_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  logic [W-1:0] ops [N];

  // model state
  int           m_ptr = 0;
  bit           m_full = 1'b0;
  logic [W-1:0] m_data = '0;
  int           m_tag = 0;
  bit           m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [W-1:0] ref_abs(input logic [W-1:0] x);
    int s;
    int m;
    logic [W-1:0] r;
    s = int'(x);
    if (s >= 32768) s = s - 65536;
    m = (s < 0) ? -s : s;
    r = m[W-1:0];
    return r;
  endfunction

  // One clock: drive at negedge, check grant, advance model at posedge, check outputs.
  task automatic cycle(input bit rst, input logic [N-1:0] v, input bit want_yumi);
    bit gv;
    int gi;
    logic [N-1:0] exp_ready;
    reset_i = rst;
    v_i = v;
    for (int i = 0; i < N; i++) data_i[i*W +: W] = ops[i];
    yumi_i = want_yumi & m_full;
    #1;
    gv = 1'b0;
    gi = 0;
    if (!rst && (!m_full || yumi_i)) begin
      for (int k = 0; k < N; k++) begin
        if (!gv && v[(m_ptr + k) % N]) begin
          gv = 1'b1;
          gi = (m_ptr + k) % N;
        end
      end
    end
    exp_ready = '0;
    if (gv) exp_ready[gi] = 1'b1;
    check("ready_o", 32'(ready_o), 32'(exp_ready));
    @(posedge clk);
    if (rst) begin
      m_full = 1'b0; m_data = '0; m_tag = 0; m_ovf = 1'b0; m_ptr = 0;
    end else if (gv) begin
      m_full = 1'b1;
      m_data = ref_abs(ops[gi]);
      m_tag  = gi;
      m_ovf  = (ops[gi] == 16'h8000);
      m_ptr  = (gi + 1) % N;
    end else if (yumi_i) begin
      m_full = 1'b0;
    end
    @(negedge clk);
    check("v_o", 32'(v_o), 32'(m_full));
    check("data_o", 32'(data_o), 32'(m_data));
    check("tag_o", 32'(tag_o), 32'(m_tag));
    check("ovf_o", 32'(ovf_o), 32'(m_ovf));
  endtask

  initial begin
    for (int i = 0; i < N; i++) ops[i] = 16'h0000;
    @(negedge clk);
    // reset
    cycle(1'b1, 4'b1111, 1'b0);
    cycle(1'b1, 4'b1111, 1'b0);
    check("reset_data", 32'(data_o), 32'h0);
    // single request from lane 2
    ops[2] = 16'hFFFB;
    cycle(1'b0, 4'b0100, 1'b1);
    check("abs_fffb", 32'(data_o), 32'h0005);
    // most-negative and most-positive operands
    ops[0] = 16'h8000;
    cycle(1'b0, 4'b0001, 1'b1);
    check("ovf_8000", {16'h0, ovf_o, data_o[14:0]}, {16'h0, 1'b1, 15'h0});
    ops[0] = 16'h7FFF;
    cycle(1'b0, 4'b0001, 1'b1);
    check("abs_7fff", 32'(data_o), 32'h7FFF);
    ops[1] = 16'h0000; ops[3] = 16'hFFFF;
    // all requesting, consumer always takes: rotating tags, no bubbles
    for (int c = 0; c < 8; c++) cycle(1'b0, 4'b1111, 1'b1);
    // land on tag 1, then backpressure
    cycle(1'b0, 4'b0010, 1'b1);
    check("t5_tag1", 32'(tag_o), 32'd1);
    for (int c = 0; c < 3; c++) cycle(1'b0, 4'b1111, 1'b0);
    cycle(1'b0, 4'b1111, 1'b1);
    check("t5_tag2", 32'(tag_o), 32'd2);
    // reset while full with a pending grant
    cycle(1'b1, 4'b1111, 1'b1);
    check("rst_mid_v", 32'(v_o), 32'd0);
    cycle(1'b0, 4'b1010, 1'b0);
    check("rst_first_grant", 32'(tag_o), 32'd1);
    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom_range(0, 7))
          0:       ops[i] = 16'h8000;
          1:       ops[i] = 16'h0000;
          2:       ops[i] = 16'hFFFF;
          default: ops[i] = 16'($urandom);
        endcase
      end
      cycle(($urandom_range(0, 49) == 0), 4'($urandom), ($urandom_range(0, 3) != 0));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
